// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with a 2-flop input synchronizer and a small byte FIFO.
// Defining UART_RX_PARITY_EN adds an even-parity bit (8E1) and the parity_error pulse.
module uart_rx #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       rxd,
  output logic [7:0] data,
  output logic       valid,
  input  logic       ready,
  output logic       overrun,
  output logic       frame_error
`ifdef UART_RX_PARITY_EN
  ,
  output logic       parity_error
`endif
);
  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam int          CW        = AW + 1;
  localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_LAST = 16'((CLKS_PER_BIT / 2) - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START     = 3'd1,
    DATA      = 3'd2,
    STOP      = 3'd3,
    WAIT_HIGH = 3'd4
`ifdef UART_RX_PARITY_EN
    ,
    PARITY    = 3'd5
`endif
  } state_e;

`ifdef UART_RX_PARITY_EN
  localparam state_e AFTER_DATA = PARITY;
`else
  localparam state_e AFTER_DATA = STOP;
`endif

  logic          sync1_q, sync2_q, rx_s;
  state_e        state_q, state_d;
  logic [15:0]   clk_cnt_q, clk_cnt_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    shift_q, shift_d;
  logic          frame_error_q, frame_error_d;
  logic          overrun_q, overrun_d;
  logic          push_s, pop_s, full_s, push_ok_s;
  logic [7:0]    mem_q [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q, count_d;
`ifdef UART_RX_PARITY_EN
  logic          par_err_q, par_err_d;
  logic          par_bad_q, par_bad_d;
`endif

  assign rx_s = sync2_q;

  // Receive FSM: next state, bit timing and byte assembly
  always_comb begin
    state_d       = state_q;
    clk_cnt_d     = clk_cnt_q + 16'd1;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    push_s        = 1'b0;
    frame_error_d = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_d     = 1'b0;
    par_bad_d     = par_bad_q;
`endif
    case (state_q)
      IDLE: begin
        clk_cnt_d = 16'd0;
        bit_cnt_d = 3'd0;
        if (!rx_s) state_d = START;
        else       state_d = IDLE;
      end
      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_d = 16'd0;
`ifdef UART_RX_PARITY_EN
          par_bad_d = 1'b0;
`endif
          if (rx_s) state_d = IDLE;
          else      state_d = DATA;
        end else begin
          state_d = START;
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = 16'd0;
          shift_d   = {rx_s, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = AFTER_DATA;
          else                   state_d = DATA;
        end else begin
          state_d = DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = 16'd0;
          state_d   = STOP;
          if ((^shift_q) ^ rx_s) begin
            par_err_d = 1'b1;
            par_bad_d = 1'b1;
          end else begin
            par_bad_d = 1'b0;
          end
        end else begin
          state_d = PARITY;
        end
      end
`endif
      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = 16'd0;
          if (rx_s) begin
`ifdef UART_RX_PARITY_EN
            push_s = !par_bad_q;
`else
            push_s = 1'b1;
`endif
            state_d = IDLE;
          end else begin
            frame_error_d = 1'b1;
            state_d       = WAIT_HIGH;
          end
        end else begin
          state_d = STOP;
        end
      end
      WAIT_HIGH: begin
        clk_cnt_d = 16'd0;
        if (rx_s) state_d = IDLE;
        else      state_d = WAIT_HIGH;
      end
      default: begin
        clk_cnt_d = 16'd0;
        state_d   = IDLE;
      end
    endcase
  end

  // FIFO control: a pop frees the slot a same-cycle push into a full FIFO needs
  always_comb begin
    pop_s     = valid && ready;
    full_s    = (count_q == CW'(FIFO_DEPTH));
    push_ok_s = push_s && (!full_s || pop_s);
    overrun_d = push_s && full_s && !pop_s;
    case ({push_ok_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // State, synchronizer, FIFO storage and registered pulse outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1_q       <= 1'b1;
      sync2_q       <= 1'b1;
      state_q       <= IDLE;
      clk_cnt_q     <= 16'd0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      frame_error_q <= 1'b0;
      overrun_q     <= 1'b0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h00;
`ifdef UART_RX_PARITY_EN
      par_err_q     <= 1'b0;
      par_bad_q     <= 1'b0;
`endif
    end else begin
      sync1_q       <= rxd;
      sync2_q       <= sync1_q;
      state_q       <= state_d;
      clk_cnt_q     <= clk_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      frame_error_q <= frame_error_d;
      overrun_q     <= overrun_d;
      count_q       <= count_d;
      if (push_ok_s) begin
        mem_q[wr_ptr_q] <= shift_q;
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop_s) rd_ptr_q <= rd_ptr_q + AW'(1);
`ifdef UART_RX_PARITY_EN
      par_err_q     <= par_err_d;
      par_bad_q     <= par_bad_d;
`endif
    end
  end

  assign valid       = (count_q != '0);
  assign data        = mem_q[rd_ptr_q];
  assign overrun     = overrun_q;
  assign frame_error = frame_error_q;
`ifdef UART_RX_PARITY_EN
  assign parity_error = par_err_q;
`endif

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 868, clock cycles per UART bit (100 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have parameter FIFO_DEPTH, default 4, number of received bytes buffered; power of two, 2..16.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-005 SHALL have port rxd  input  1  asynchronous serial line; idle high; 8N1 frame, LSB first.
REQ-006 SHALL have port data  output  8  byte at FIFO head; valid only while valid=1.
REQ-007 SHALL have port valid  output  1  FIFO non-empty.
REQ-008 SHALL have port ready  input  1  consumer accepts head byte when valid&&ready.
REQ-009 SHALL have port overrun  output  1  one-cycle pulse when a good byte is dropped because the FIFO is full.
REQ-010 SHALL have port frame_error  output  1  one-cycle pulse when the stop bit samples 0.

Function
REQ-011 SHALL pass rxd through a 2-flop synchronizer; all decisions use the synchronized value.
REQ-012 SHALL implement states IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-013 IDLE: synchronized rxd=0 -> START, bit counter cleared.
REQ-014 START: after CLKS_PER_BIT/2 cycles (integer division), sample; 1 -> IDLE (glitch, nothing reported); 0 -> DATA.
REQ-015 DATA: sample every CLKS_PER_BIT cycles; shift sampled bit in at bit 7 and shift right; after 8 samples -> STOP.
REQ-016 STOP: sample CLKS_PER_BIT cycles after the last data bit; 1 -> push byte, -> IDLE; 0 -> pulse frame_error, discard byte, -> WAIT_HIGH.
REQ-017 WAIT_HIGH: remain until synchronized rxd=1, then -> IDLE; a held-low line SHALL NOT produce repeated frames.
REQ-018 Push into a full FIFO with no simultaneous pop SHALL drop the new byte, keep FIFO contents, and pulse overrun.
REQ-019 Push and pop in the same cycle SHALL both take effect, including when the FIFO is full; no overrun is reported.
REQ-020 A byte pushed into an empty FIFO SHALL appear with valid=1 on the cycle after the push.
REQ-021 Pop SHALL occur only when valid&&ready; ready with valid=0 SHALL have no effect.
REQ-022 data SHALL be stable while valid=1 and ready=0.
REQ-023 Bytes SHALL be delivered in reception order; read/write pointers wrap modulo FIFO_DEPTH; count width is log2(FIFO_DEPTH)+1 bits.

Reset
REQ-024 While reset_n=0 at a clock edge: state=IDLE, counters=0, FIFO empty, valid=0, data=0, overrun=0, frame_error=0, synchronizer flops=1.
REQ-025 Reset asserted mid-frame SHALL abandon the partial byte; after release, the remainder of that frame is treated as line activity starting from IDLE.

Configuration
REQ-026 Macro UART_RX_PARITY_EN: when defined, SHALL add state PARITY between DATA and STOP expecting even parity, and SHALL add output port parity_error (1-bit, one-cycle pulse; reset 0).
REQ-027 With UART_RX_PARITY_EN defined, a parity mismatch SHALL pulse parity_error, discard the byte, and continue to STOP; the frame-error rule still applies.
REQ-028 Without UART_RX_PARITY_EN, the frame SHALL be 8N1, PARITY and parity_error SHALL not exist, and behaviour SHALL be exactly REQ-011..REQ-023.

Verification (CLKS_PER_BIT=16, FIFO_DEPTH=4)
REQ-029 Send 0x55 with ready=1 -> exactly one valid&&ready beat with data=0x55; overrun=0; frame_error=0.
REQ-030 Drive rxd low for 4 cycles, then high -> valid remains 0 and no error pulses (glitch rejected in START).
REQ-031 Send 0x01,0x02,0x03,0x04,0x05 with ready=0 -> one overrun pulse at the fifth stop sample; then with ready=1, pops 0x01..0x04 in order and valid=0.
REQ-032 Send 0xA3 with stop bit 0 and rxd held low for 40 cycles -> one frame_error pulse, no push, stays in WAIT_HIGH; a following 0x7E is received correctly.
REQ-033 Assert reset_n=0 for 1 cycle during data bit 4 -> valid=0 and state IDLE the next cycle; a later 0xC8 is received correctly.
REQ-034 With UART_RX_PARITY_EN defined, send 0x07 with parity bit 0 -> parity_error pulse and no push; send 0x07 with parity bit 1 -> data=0x07 received.
